// File: rtl/scancode_decode.sv
// rtl/scancode_decode.sv - PS/2 set-2 scancode prefix folder with show-ahead event FIFO
//
// Purpose:
//   Takes bytes from the PS/2 frame parser and folds the E0 (extended),
//   F0 (break) and E1 (Pause) prefix sequences into single key events.
//   Events are queued in a small show-ahead FIFO. The consumer drains it
//   with a valid/ready handshake.
//
// Parameters:
//   FIFO_DEPTH   number of event slots (power of 2, >= 2)
//   TIMEOUT_CYC  idle sysclk cycles before a partial prefix sequence is abandoned
//
// Optional feature (macro MODIFIER_TRACK_EN):
//   When the macro is defined, mods tracks the make/break state of the eight
//   modifier keys. When it is not defined, mods is tied to 8'h00.
//
// Ports:
//   sysclk     in   1  system clock, all logic on posedge
//   rst_n      in   1  asynchronous active-low reset
//   word       in   8  byte from the parser, sampled when done=1
//   done       in   1  one-cycle strobe marking a complete byte
//   key_valid  out  1  the FIFO head holds an event
//   key_ready  in   1  the consumer accepts the head
//   key_code   out  8  head event scancode
//   key_ext    out  1  head event was extended (E0) or Pause
//   key_break  out  1  head event is a release
//   ovf        out  1  sticky flag: an event was dropped on a full FIFO
//   ovf_clr    in   1  clears ovf
//   err        out  1  one-cycle pulse for keyboard error code 00/FF
//   mods       out  8  modifier key state
module scancode_decode #(
  parameter int FIFO_DEPTH  = 4,
  parameter int TIMEOUT_CYC = 2000
) (
  input  logic       sysclk,
  input  logic       rst_n,
  input  logic [7:0] word,
  input  logic       done,
  output logic       key_valid,
  input  logic       key_ready,
  output logic [7:0] key_code,
  output logic       key_ext,
  output logic       key_break,
  output logic       ovf,
  input  logic       ovf_clr,
  output logic       err,
  output logic [7:0] mods
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_EXT,
    ST_BRK,
    ST_EXTBRK,
    ST_PAUSE
  } state_t;

  state_t          r_state;
  logic [2:0]      r_pcnt;
  logic [TW-1:0]   r_tcnt;
  logic            r_err;

  // Combinational decode of the byte that is arriving in the current state.
  logic            w_push;
  logic            w_ev_ext;
  logic            w_ev_brk;
  logic [7:0]      w_ev_code;
  logic [9:0]      w_ev;

  always_comb begin
    w_push    = 1'b0;
    w_ev_ext  = 1'b0;
    w_ev_brk  = 1'b0;
    w_ev_code = word;
    if (done) begin
      case (r_state)
        ST_IDLE: begin
          if (!(word inside {8'hE0, 8'hF0, 8'hE1, 8'hAA, 8'hFA,
                             8'hEE, 8'hFE, 8'h00, 8'hFF}))
            w_push = 1'b1;
        end
        ST_EXT: begin
          if (word != 8'hF0 && word != 8'hE0) begin
            w_push   = 1'b1;
            w_ev_ext = 1'b1;
          end
        end
        ST_BRK: begin
          // Any byte after F0 is the released key, even a prefix value.
          w_push   = 1'b1;
          w_ev_brk = 1'b1;
        end
        ST_EXTBRK: begin
          w_push   = 1'b1;
          w_ev_ext = 1'b1;
          w_ev_brk = 1'b1;
        end
        ST_PAUSE: begin
          // The rest of the Pause sequence is fixed, so its bytes are
          // counted rather than parsed.
          if (r_pcnt == 3'd6) begin
            w_push    = 1'b1;
            w_ev_ext  = 1'b1;
            w_ev_code = 8'h77;
          end
        end
        default: ;
      endcase
    end
  end

  assign w_ev = {w_ev_ext, w_ev_brk, w_ev_code};

  // Prefix state machine with the abandon timer and the error pulse.
  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_pcnt  <= 3'd0;
      r_tcnt  <= '0;
      r_err   <= 1'b0;
    end else begin
      r_err <= 1'b0;
      if (done) begin
        r_tcnt <= '0;
        case (r_state)
          ST_IDLE: begin
            case (word)
              8'hE0: r_state <= ST_EXT;
              8'hF0: r_state <= ST_BRK;
              8'hE1: begin
                r_state <= ST_PAUSE;
                r_pcnt  <= 3'd0;
              end
              8'h00, 8'hFF: r_err <= 1'b1;
              default: r_state <= ST_IDLE;
            endcase
          end
          ST_EXT: begin
            if (word == 8'hF0)
              r_state <= ST_EXTBRK;
            else if (word != 8'hE0)
              r_state <= ST_IDLE;
          end
          ST_BRK:    r_state <= ST_IDLE;
          ST_EXTBRK: r_state <= ST_IDLE;
          ST_PAUSE: begin
            if (r_pcnt == 3'd6)
              r_state <= ST_IDLE;
            else
              r_pcnt <= r_pcnt + 3'd1;
          end
          default: r_state <= ST_IDLE;
        endcase
      end else if (r_state != ST_IDLE) begin
        if (r_tcnt == TW'(TIMEOUT_CYC - 1)) begin
          r_state <= ST_IDLE;
          r_tcnt  <= '0;
        end else begin
          r_tcnt <= r_tcnt + TW'(1);
        end
      end
    end
  end

  // Event FIFO. The count decides full and empty. The head registers are
  // loaded from the contents as they stand after this edge's pop but before
  // this edge's push. Because of that, a new entry shows up one cycle after
  // it is written, and a popped head is never shown again.
  logic [9:0]      r_mem [FIFO_DEPTH];
  logic [AW-1:0]   r_wr_ptr;
  logic [AW-1:0]   r_rd_ptr;
  logic [CW-1:0]   r_count;
  logic            r_key_valid;
  logic            r_key_ext;
  logic            r_key_break;
  logic [7:0]      r_key_code;
  logic            r_ovf;

  logic            w_pop;
  logic            w_full;
  logic            w_wr;
  logic            w_drop;
  logic [AW-1:0]   w_rd_nxt;
  logic            w_vis_nxt;

  assign w_pop     = r_key_valid & key_ready;
  assign w_full    = (r_count == CW'(FIFO_DEPTH));
  assign w_wr      = w_push & (~w_full | w_pop);
  assign w_drop    = w_push & w_full & ~w_pop;
  assign w_rd_nxt  = r_rd_ptr + AW'(w_pop);
  assign w_vis_nxt = ((r_count - CW'(w_pop)) != '0);

  always_ff @(posedge sysclk) begin
    if (w_wr)
      r_mem[r_wr_ptr] <= w_ev;
  end

  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_key_valid <= 1'b0;
      r_key_ext   <= 1'b0;
      r_key_break <= 1'b0;
      r_key_code  <= 8'h00;
      r_ovf       <= 1'b0;
    end else begin
      if (w_wr)
        r_wr_ptr <= r_wr_ptr + AW'(1);
      r_rd_ptr    <= w_rd_nxt;
      r_count     <= r_count + CW'(w_wr) - CW'(w_pop);
      r_key_valid <= w_vis_nxt;
      if (w_vis_nxt)
        {r_key_ext, r_key_break, r_key_code} <= r_mem[w_rd_nxt];
      else
        {r_key_ext, r_key_break, r_key_code} <= 10'h000;
      // A drop in the same cycle as a clear leaves the flag set.
      if (w_drop)
        r_ovf <= 1'b1;
      else if (ovf_clr)
        r_ovf <= 1'b0;
    end
  end

  assign key_valid = r_key_valid;
  assign key_ext   = r_key_ext;
  assign key_break = r_key_break;
  assign key_code  = r_key_code;
  assign ovf       = r_ovf;
  assign err       = r_err;

`ifdef MODIFIER_TRACK_EN
  // Modifiers follow every decoded event, including events the full FIFO
  // drops, so the key state stays correct when the consumer stalls.
  logic [7:0] r_mods;
  logic [7:0] w_mod_sel;

  always_comb begin
    w_mod_sel = 8'h00;
    case ({w_ev_ext, w_ev_code})
      9'h012:  w_mod_sel = 8'h01;
      9'h059:  w_mod_sel = 8'h02;
      9'h014:  w_mod_sel = 8'h04;
      9'h114:  w_mod_sel = 8'h08;
      9'h011:  w_mod_sel = 8'h10;
      9'h111:  w_mod_sel = 8'h20;
      9'h11F:  w_mod_sel = 8'h40;
      9'h127:  w_mod_sel = 8'h80;
      default: w_mod_sel = 8'h00;
    endcase
  end

  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n)
      r_mods <= 8'h00;
    else if (w_push)
      r_mods <= w_ev_brk ? (r_mods & ~w_mod_sel) : (r_mods | w_mod_sel);
  end

  assign mods = r_mods;
`else
  assign mods = 8'h00;
`endif

endmodule
